// File: rtl/bsg_piso_pkg.sv
// Shared definitions for the length-aware parallel-in/serial-out passthrough.
package bsg_piso_pkg;

  // Distance between els_p and the largest legal element index.
  localparam int unsigned piso_len_clamp_margin_lp = 1;

  // Index width that stays at least one bit wide, even for a single element.
  function automatic int unsigned piso_safe_clog2(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Effective last index: requested length, saturated at the last element slot.
  function automatic int unsigned piso_clamp_len(input int unsigned len,
                                                 input int unsigned els);
    int unsigned max_len;
    max_len = els - piso_len_clamp_margin_lp;
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/bsg_piso_len_counter.sv
// Element counter for the PISO passthrough: walks 0..len_eff, then clears on
// the transfer of the final element.
module bsg_piso_len_counter
  import bsg_piso_pkg::*;
#(
  parameter int els_p     = 1,
  parameter int lg_els_lp = piso_safe_clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 yumi_i,
  input  logic [lg_els_lp-1:0] len_i,
  output logic [lg_els_lp-1:0] count_o,
  output logic                 is_last_o
);

  logic [lg_els_lp-1:0] count_q, count_d;
  logic [lg_els_lp-1:0] len_eff_s;
  logic                 is_last_s;

  // Clamp the requested length and detect the final element of the word.
  always_comb begin
    len_eff_s = lg_els_lp'(piso_clamp_len(32'(len_i), els_p));
    is_last_s = (count_q == len_eff_s);
  end

  // Advance on each accepted element, wrap to zero after the last one.
  always_comb begin
    count_d = count_q;
    if (els_p == 1) begin
      count_d = {lg_els_lp{1'b0}};
    end else if (yumi_i) begin
      if (is_last_s) begin
        count_d = {lg_els_lp{1'b0}};
      end else begin
        count_d = count_q + lg_els_lp'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Element index register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= {lg_els_lp{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_last_o = is_last_s;

endmodule

// File: rtl/bsg_parallel_in_serial_out_passthrough_len.sv
// Parallel-in/serial-out passthrough with per-word length. No data storage:
// the upstream holds its word until ready_and_o, which rises together with
// the final serial element.
// Optional build macro BSG_PISO_PASSTHROUGH_STABILITY_CHECK_EN adds shadow
// registers that flag (sticky err_o) any change of v_i/data_i/len_i mid-word.
module bsg_parallel_in_serial_out_passthrough_len
  import bsg_piso_pkg::*;
#(
  parameter  int width_p    = 1,
  parameter  int els_p      = 1,
  parameter  int hi_to_lo_p = 0,
  localparam int lg_els_lp  = piso_safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [lg_els_lp-1:0]     len_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic                     ready_and_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o,
  input  logic                     ready_and_i,
  output logic                     err_o
);

  typedef logic [els_p-1:0][width_p-1:0] word_t;

  word_t                word_s;
  logic [lg_els_lp-1:0] count_s;
  logic [lg_els_lp-1:0] idx_s;
  logic                 is_last_s;
  logic                 transfer_s;

  assign word_s     = data_i;
  assign transfer_s = v_i & ready_and_i;

  bsg_piso_len_counter #(
    .els_p     (els_p),
    .lg_els_lp (lg_els_lp)
  ) counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .yumi_i    (transfer_s),
    .len_i     (len_i),
    .count_o   (count_s),
    .is_last_o (is_last_s)
  );

  // Optional index reversal ahead of the element mux.
  always_comb begin
    if (hi_to_lo_p != 0) begin
      idx_s = lg_els_lp'(els_p - 1) - count_s;
    end else begin
      idx_s = count_s;
    end
  end

  // Serial side is a pure combinational view of the held parallel word.
  always_comb begin
    v_o         = v_i;
    data_o      = word_s[idx_s];
    last_o      = v_i & is_last_s;
    ready_and_o = transfer_s & is_last_s;
  end

`ifdef BSG_PISO_PASSTHROUGH_STABILITY_CHECK_EN
  logic [els_p*width_p-1:0] shadow_data_q, shadow_data_d;
  logic [lg_els_lp-1:0]     shadow_len_q, shadow_len_d;
  logic                     err_q, err_d;
  logic                     busy_s, capture_s, mismatch_s;

  // Snapshot the word on its first beat, then watch it while mid-word.
  always_comb begin
    busy_s        = (count_s != {lg_els_lp{1'b0}});
    capture_s     = ~busy_s & transfer_s & ~is_last_s;
    mismatch_s    = busy_s & (~v_i | (data_i != shadow_data_q) | (len_i != shadow_len_q));
    shadow_data_d = capture_s ? data_i : shadow_data_q;
    shadow_len_d  = capture_s ? len_i  : shadow_len_q;
    err_d         = err_q | mismatch_s;
  end

  // Shadow copy and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_data_q <= {(els_p*width_p){1'b0}};
      shadow_len_q  <= {lg_els_lp{1'b0}};
      err_q         <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_len_q  <= shadow_len_d;
      err_q         <= err_d;
    end
  end

  // Simulation notice on the cycle the upstream breaks the hold contract.
  always_ff @(posedge clk_i) begin
    if (!reset_i && mismatch_s) begin
      $error("piso passthrough: upstream word changed mid-transfer");
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
